// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial link (TX serialiser / RX deserialiser).
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Number of LANES-wide beats needed to carry frame_w bits.
    function automatic int beats(input int frame_w, input int lanes);
        return (frame_w + lanes - 1) / lanes;
    endfunction

    // Beat counter width able to hold every value 0..n inclusive.
    function automatic int beat_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_deser.sv
// serial_deser: RX side of the serial link. Collects MSB-first beats into a frame,
// optionally checks a trailing lane-wise even-parity beat, and holds the last good frame.
module serial_deser
    import serial_pkg::*;
#(
    parameter int PKT_W  = 42,
    parameter int PAD_W  = 4,
    parameter int LANES  = 1,
    parameter int PAR_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid_i,
    input  logic             ser_sof_i,
    input  logic [LANES-1:0] ser_data_i,
    input  logic             flush,
    output logic             receiver_valid,
    output logic [PAD_W-1:0] receiver_padding,
    output logic [PKT_W-1:0] receiver_packet,
    output logic             rx_err
);

    localparam int FRAME_W   = PAD_W + PKT_W;
    localparam int BEATS     = beats(FRAME_W, LANES);
    localparam int PADDED_W  = BEATS * LANES;
    localparam int TOT_BEATS = BEATS + ((PAR_EN != 0) ? 1 : 0);
    localparam int CNT_W     = beat_cnt_w(TOT_BEATS);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] PAR_BEAT  = CNT_W'(BEATS);

    // Lane-wise even-parity accumulation of one beat.
    function automatic logic [LANES-1:0] par_fold(input logic [LANES-1:0] acc,
                                                  input logic [LANES-1:0] beat);
        return acc ^ beat;
    endfunction

    logic                active_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [PADDED_W-1:0] shift_r;
    logic [LANES-1:0]    par_r;
    logic                valid_r;
    logic [FRAME_W-1:0]  held_r;
    logic                err_r;

    logic                beat_ok_s;
    logic [CNT_W-1:0]    idx_s;
    logic [PADDED_W-1:0] shift_in_s;
    logic [PADDED_W-1:0] shift_acc_s;
    logic [LANES-1:0]    par_acc_s;
    logic                par_beat_s;
    logic                data_last_s;

    // Classify the incoming beat: an SOF restarts at index 0, otherwise continue the frame.
    always_comb begin
        beat_ok_s  = ser_valid_i && (ser_sof_i || active_r);
        shift_in_s = '0;
        shift_in_s[LANES-1:0] = ser_data_i;
        if (ser_sof_i) begin
            idx_s       = '0;
            shift_acc_s = shift_in_s;
            par_acc_s   = ser_data_i;
        end else begin
            idx_s       = cnt_r;
            shift_acc_s = (shift_r << LANES) | shift_in_s;
            par_acc_s   = par_fold(par_r, ser_data_i);
        end
        par_beat_s  = (PAR_EN != 0) && (idx_s == PAR_BEAT);
        data_last_s = (PAR_EN == 0) && (idx_s == LAST_DATA);
    end

    // Frame assembly, held-frame update and error pulse; flush overrides a completing frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= 1'b0;
            cnt_r    <= '0;
            shift_r  <= '0;
            par_r    <= '0;
            valid_r  <= 1'b0;
            held_r   <= '0;
            err_r    <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (flush) begin
                active_r <= 1'b0;
                cnt_r    <= '0;
                valid_r  <= 1'b0;
                held_r   <= '0;
            end else if (!beat_ok_s) begin
                // No beat, a gap mid-frame, or stray beats before any SOF: nothing in progress.
                active_r <= 1'b0;
                cnt_r    <= '0;
            end else if (par_beat_s) begin
                active_r <= 1'b0;
                cnt_r    <= '0;
                if (par_r == ser_data_i) begin
                    valid_r <= 1'b1;
                    held_r  <= shift_r[PADDED_W-1 -: FRAME_W];
                end else begin
                    err_r <= 1'b1;
                end
            end else if (data_last_s) begin
                active_r <= 1'b0;
                cnt_r    <= '0;
                valid_r  <= 1'b1;
                held_r   <= shift_acc_s[PADDED_W-1 -: FRAME_W];
            end else begin
                active_r <= 1'b1;
                cnt_r    <= idx_s + CNT_W'(1'b1);
                shift_r  <= shift_acc_s;
                par_r    <= par_acc_s;
            end
        end
    end

    assign receiver_valid   = valid_r;
    assign receiver_padding = held_r[FRAME_W-1 -: PAD_W];
    assign receiver_packet  = held_r[PKT_W-1:0];
    assign rx_err           = err_r;

endmodule

// File: rtl/serial_link.sv
// serial_link: TX serialiser plus RX deserialiser (serial_deser) on one clock.
// Frame = {padding, packet}, sent MSB first, last beat MSB-aligned and zero-filled.
// Build option SERIAL_LINK_PARITY_EN: TX appends a lane-wise even-parity beat and RX checks it.
module serial_link
    import serial_pkg::*;
#(
    parameter int PKT_W = 42,
    parameter int PAD_W = 4,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAD_W-1:0] sender_padding,
    input  logic [PKT_W-1:0] sender_packet,
    input  logic             sender_enable,
    output logic             sender_ack,
    output logic             ser_valid_o,
    output logic             ser_sof_o,
    output logic [LANES-1:0] ser_data_o,
    input  logic             ser_valid_i,
    input  logic             ser_sof_i,
    input  logic [LANES-1:0] ser_data_i,
    input  logic             flush,
    output logic             receiver_valid,
    output logic [PAD_W-1:0] receiver_padding,
    output logic [PKT_W-1:0] receiver_packet,
    output logic             rx_err
);

    localparam int FRAME_W  = PAD_W + PKT_W;
    localparam int BEATS    = beats(FRAME_W, LANES);
    localparam int PADDED_W = BEATS * LANES;
`ifdef SERIAL_LINK_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif
    localparam int TOT_BEATS = BEATS + PAR_BEATS;
    localparam int CNT_W     = beat_cnt_w(TOT_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOT_BEATS - 1);
    localparam logic [CNT_W-1:0] PAR_BEAT  = CNT_W'(BEATS);

    // Lane-wise even-parity accumulation of one beat.
    function automatic logic [LANES-1:0] par_fold(input logic [LANES-1:0] acc,
                                                  input logic [LANES-1:0] beat);
        return acc ^ beat;
    endfunction

    tx_state_e           state_r, state_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic [PADDED_W-1:0] shift_r, shift_nx_s, frame_s;
    logic [LANES-1:0]    par_r, par_nx_s;
    logic [LANES-1:0]    data_r, data_nx_s;
    logic                ack_r, ack_nx_s;
    logic                valid_r, valid_nx_s;
    logic                sof_r, sof_nx_s;

    // MSB-align the frame into the padded beat grid; trailing bits are zero.
    always_comb begin
        frame_s = '0;
        frame_s[PADDED_W-1 -: FRAME_W] = {sender_padding, sender_packet};
    end

    // TX next state and next registered outputs. The state returns to IDLE while the
    // last beat is on the wire so a held enable starts the next frame with no gap.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        shift_nx_s = shift_r;
        par_nx_s   = par_r;
        ack_nx_s   = 1'b0;
        valid_nx_s = 1'b0;
        sof_nx_s   = 1'b0;
        data_nx_s  = '0;
        case (state_r)
            IDLE: begin
                if (sender_enable) begin
                    ack_nx_s   = 1'b1;
                    valid_nx_s = 1'b1;
                    sof_nx_s   = 1'b1;
                    data_nx_s  = frame_s[PADDED_W-1 -: LANES];
                    par_nx_s   = frame_s[PADDED_W-1 -: LANES];
                    shift_nx_s = frame_s << LANES;
                    cnt_nx_s   = CNT_W'(1'b1);
                    if (LAST_BEAT == '0) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = SEND;
                    end
                end else begin
                    cnt_nx_s = '0;
                end
            end
            SEND: begin
                valid_nx_s = 1'b1;
                cnt_nx_s   = cnt_r + CNT_W'(1'b1);
                if ((PAR_BEATS != 0) && (cnt_r == PAR_BEAT)) begin
                    data_nx_s = par_r;
                end else begin
                    data_nx_s  = shift_r[PADDED_W-1 -: LANES];
                    par_nx_s   = par_fold(par_r, shift_r[PADDED_W-1 -: LANES]);
                    shift_nx_s = shift_r << LANES;
                end
                if (cnt_r == LAST_BEAT) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = SEND;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // TX state register, beat shifter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
            par_r   <= '0;
            data_r  <= '0;
            ack_r   <= 1'b0;
            valid_r <= 1'b0;
            sof_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            shift_r <= shift_nx_s;
            par_r   <= par_nx_s;
            data_r  <= data_nx_s;
            ack_r   <= ack_nx_s;
            valid_r <= valid_nx_s;
            sof_r   <= sof_nx_s;
        end
    end

    assign sender_ack  = ack_r;
    assign ser_valid_o = valid_r;
    assign ser_sof_o   = sof_r;
    assign ser_data_o  = data_r;

    serial_deser #(
        .PKT_W  (PKT_W),
        .PAD_W  (PAD_W),
        .LANES  (LANES),
        .PAR_EN (PAR_BEATS)
    ) u_deser (
        .clk              (clk),
        .rst              (rst),
        .ser_valid_i      (ser_valid_i),
        .ser_sof_i        (ser_sof_i),
        .ser_data_i       (ser_data_i),
        .flush            (flush),
        .receiver_valid   (receiver_valid),
        .receiver_padding (receiver_padding),
        .receiver_packet  (receiver_packet),
        .rx_err           (rx_err)
    );

endmodule

// File: tb/tb_serial_link.sv
// Loopback bench for serial_link: one 1-lane and one 4-lane instance, each wired
// ser_*_o -> ser_*_i. A cycle model predicts ack/sof/valid and a scoreboard of
// captured frames predicts when and what each receiver holds.
`timescale 1ns/1ps
module tb_serial_link;
`ifdef SERIAL_LINK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TOT0 = 46 + PAR;   // 46 one-bit beats
    localparam int TOT1 = 12 + PAR;   // ceil(46/4) = 12 four-bit beats

    typedef struct {
        int         id;
        int         cap;
        int         due;
        logic [3:0] pad;
        logic [41:0] pkt;
        bit         bad;
    } exp_t;
    exp_t q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pad_in = 4'h0;
    logic [41:0] pkt_in = 42'h0;
    logic [1:0]  en = 2'b00;
    logic [1:0]  fl = 2'b00;
    logic        flip = 1'b0;

    wire [1:0]   ack, sv, sof, rv, err;
    wire         d1_o;
    wire         d1_i;
    wire [3:0]   d4_o;
    wire [3:0]   rpad [2];
    wire [41:0]  rpkt [2];

    assign d1_i = d1_o ^ flip;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int nf [2];
    logic        exp_rv [2];
    logic [3:0]  exp_pad [2];
    logic [41:0] exp_pkt [2];
    logic        e_ack, e_err;
    int          tot, hit;
    int          cap4 = -100;
    logic [3:0]  last4_exp = 4'h0;
    int          t0;

    always #5 clk = ~clk;

    serial_link #(.PKT_W(42), .PAD_W(4), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .sender_padding(pad_in), .sender_packet(pkt_in), .sender_enable(en[0]),
        .sender_ack(ack[0]), .ser_valid_o(sv[0]), .ser_sof_o(sof[0]), .ser_data_o(d1_o),
        .ser_valid_i(sv[0]), .ser_sof_i(sof[0]), .ser_data_i(d1_i), .flush(fl[0]),
        .receiver_valid(rv[0]), .receiver_padding(rpad[0]), .receiver_packet(rpkt[0]),
        .rx_err(err[0])
    );

    serial_link #(.PKT_W(42), .PAD_W(4), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .sender_padding(pad_in), .sender_packet(pkt_in), .sender_enable(en[1]),
        .sender_ack(ack[1]), .ser_valid_o(sv[1]), .ser_sof_o(sof[1]), .ser_data_o(d4_o),
        .ser_valid_i(sv[1]), .ser_sof_i(sof[1]), .ser_data_i(d4_o), .flush(fl[1]),
        .receiver_valid(rv[1]), .receiver_padding(rpad[1]), .receiver_packet(rpkt[1]),
        .rx_err(err[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model + scoreboard, evaluated 1 ns after every rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            tot   = (k == 0) ? TOT0 : TOT1;
            e_ack = 1'b0;
            e_err = 1'b0;
            if (rst) begin
                nf[k] = 0; exp_rv[k] = 1'b0; exp_pad[k] = 4'h0; exp_pkt[k] = 42'h0;
                for (int i = q.size() - 1; i >= 0; i--) if (q[i].id == k) q.delete(i);
            end else begin
                if (fl[k]) begin
                    exp_rv[k] = 1'b0; exp_pad[k] = 4'h0; exp_pkt[k] = 42'h0;
                    for (int i = q.size() - 1; i >= 0; i--)
                        if (q[i].id == k && q[i].cap < cyc) q.delete(i);
                end else begin
                    hit = -1;
                    for (int i = 0; i < q.size(); i++)
                        if (hit < 0 && q[i].id == k && q[i].due == cyc) hit = i;
                    if (hit >= 0) begin
                        if (q[hit].bad) begin
                            e_err = 1'b1;
                        end else begin
                            exp_rv[k] = 1'b1; exp_pad[k] = q[hit].pad; exp_pkt[k] = q[hit].pkt;
                        end
                        q.delete(hit);
                    end
                end
                if (en[k] && cyc >= nf[k]) begin
                    e_ack = 1'b1;
                    nf[k] = cyc + tot;
                    q.push_back('{k, cyc, cyc + tot, pad_in, pkt_in, 1'b0});
                    if (k == 1) begin
                        cap4 = cyc;
                        last4_exp = {pkt_in[1:0], 2'b00};
                    end
                end
            end
            check_eq($sformatf("ack%0d", k), ack[k], e_ack);
            check_eq($sformatf("sof%0d", k), sof[k], e_ack);
            check_eq($sformatf("ser_valid%0d", k), sv[k], (cyc < nf[k]));
            check_eq($sformatf("rx_valid%0d", k), rv[k], exp_rv[k]);
            check_eq($sformatf("rx_pad%0d", k), rpad[k], exp_pad[k]);
            check_eq($sformatf("rx_pkt%0d", k), rpkt[k], exp_pkt[k]);
            check_eq($sformatf("rx_err%0d", k), err[k], e_err);
        end
        if (!rst && cyc == cap4 + 11) check_eq("last_beat4", d4_o, last4_exp);
    end

    task automatic wait_ack(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (ack[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("ack_wait", ack[k], 1'b1);
    endtask

    task automatic send(input int k, input logic [3:0] p, input logic [41:0] d);
        @(negedge clk);
        pad_in = p;
        pkt_in = d;
        en[k]  = 1'b1;
        wait_ack(k);
        en[k]  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", (q.size() == 0), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        nf[0] = 0; nf[1] = 0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        exp_pad[0] = 4'h0; exp_pad[1] = 4'h0;
        exp_pkt[0] = 42'h0; exp_pkt[1] = 42'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Enable held high: two back-to-back frames, second overwrites the first.
        @(negedge clk);
        pad_in = 4'b1011; pkt_in = 42'h2AC19440329; en[0] = 1'b1;
        wait_ack(0);
        t0 = cyc;
        pad_in = 4'h6; pkt_in = 42'h3FF00AA55CC;
        wait_ack(0);
        check_eq("b2b_gap", cyc - t0, TOT0);
        en[0] = 1'b0;
        drain();

        // Flush clears the held frame; the same data is received again afterwards.
        @(negedge clk); fl[0] = 1'b1;
        @(negedge clk); fl[0] = 1'b0;
        send(0, 4'b1011, 42'h2AC19440329);
        drain();

        // Four lanes: 12 beats, last beat zero-filled.
        send(1, 4'b1011, 42'h2AC19440329);
        drain();

        // Reset in the middle of a frame, then a fresh frame.
        send(0, 4'hA, 42'h155);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(0, 4'h5, 42'h1);
        drain();

        // Flush on the completion edge drops the frame; the next one is normal.
        send(0, 4'h3, 42'h0ABCDEF1234);
        t0 = cyc;
        while (cyc < t0 + TOT0 - 1) @(negedge clk);
        fl[0] = 1'b1;
        @(negedge clk); fl[0] = 1'b0;
        drain();
        send(0, 4'h9, 42'h123456789AB);
        drain();

`ifdef SERIAL_LINK_PARITY_EN
        // One corrupted data bit on the wire: error pulse, held frame untouched.
        send(0, 4'hC, 42'h2AC19440329);
        t0 = cyc;
        q[q.size() - 1].bad = 1'b1;
        while (cyc < t0 + 5) @(negedge clk);
        flip = 1'b1;
        @(negedge clk); flip = 1'b0;
        drain();
        send(0, 4'hC, 42'h2AC19440329);
        drain();
`endif

        // Random frames launched into both links at once.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            pad_in = 4'($urandom);
            pkt_in = 42'({$urandom, $urandom});
            en = 2'b11;
            @(negedge clk);
            en = 2'b00;
            drain();
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
